cacheline_burst_adaptor: RTL and testbench

//  Bridges the L2/LLC cacheline port (one 256-bit line per request) to the

---
 rtl/cacheline_adaptor_pkg.sv | 13 +
 rtl/cacheline_burst_adaptor.sv | 122 ++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared types and default widths for the cacheline burst adaptor
package cacheline_adaptor_pkg;

  localparam int LINE_W_DEF  = 256;
  localparam int BURST_W_DEF = 64;
  localparam int ADDR_W_DEF  = 32;
  localparam int BEATS_DEF   = LINE_W_DEF / BURST_W_DEF;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  typedef logic [$clog2(BEATS_DEF)-1:0] beat_t;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - splits/assembles cacheline requests into memory bursts
// Optional perf counters built when CACHELINE_ADAPTOR_PERF_EN is defined.
module cacheline_burst_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  line_addr_i,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [LINE_W-1:0]  line_wdata_i,
  output logic [LINE_W-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [BURST_W-1:0] mem_wdata_o,
  input  logic [BURST_W-1:0] mem_rdata_i,
  input  logic               mem_resp_i,
  output logic [31:0]        perf_rd_o,
  output logic [31:0]        perf_wr_o,
  output logic [31:0]        perf_stall_o
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFFS  = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFFS){1'b1}}, {OFFS{1'b0}}};

  state_t              state, state_n;
  beat_t               beat, beat_nxt;
  logic [LINE_W-1:0]   wbuf;
  logic                last_beat;

  assign beat_nxt  = beat + 1'b1;
  assign last_beat = (int'(beat) == BEATS - 1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (line_write_i)     state_n = WR;
        else if (line_read_i) state_n = RD;
      end
      RD, WR: begin
        if (mem_resp_i && last_beat) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request/response outputs are registered off the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat         <= '0;
      wbuf         <= '0;
      line_rdata_o <= '0;
      line_resp_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_wdata_o  <= '0;
    end else begin
      mem_read_o  <= (state_n == RD);
      mem_write_o <= (state_n == WR);
      line_resp_o <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (line_write_i) begin
            wbuf        <= line_wdata_i;
            mem_addr_o  <= line_addr_i & ALIGN_MASK;
            mem_wdata_o <= line_wdata_i[BURST_W-1:0];
          end else if (line_read_i) begin
            mem_addr_o  <= line_addr_i & ALIGN_MASK;
          end
        end
        RD: begin
          if (mem_resp_i) begin
            line_rdata_o[int'(beat)*BURST_W +: BURST_W] <= mem_rdata_i;
            beat <= beat_nxt;
          end
        end
        WR: begin
          if (mem_resp_i) begin
            mem_wdata_o <= wbuf[int'(beat_nxt)*BURST_W +: BURST_W];
            beat        <= beat_nxt;
          end
        end
        DONE:    beat <= '0;
        default: beat <= '0;
      endcase
    end
  end

`ifdef CACHELINE_ADAPTOR_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_o    <= '0;
      perf_wr_o    <= '0;
      perf_stall_o <= '0;
    end else begin
      if (state == RD && state_n == DONE) perf_rd_o <= perf_rd_o + 32'd1;
      if (state == WR && state_n == DONE) perf_wr_o <= perf_wr_o + 32'd1;
      if ((mem_read_o || mem_write_o) && !mem_resp_i) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`else
  assign perf_rd_o    = '0;
  assign perf_wr_o    = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb/tb_cacheline_burst_adaptor.sv - scoreboard bench for cacheline_burst_adaptor
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_addr_i;
  logic         line_read_i, line_write_i;
  logic [255:0] line_wdata_i, line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  mem_addr_o;
  logic         mem_read_o, mem_write_o;
  logic [63:0]  mem_wdata_o, mem_rdata_i;
  logic         mem_resp_i;
  logic [31:0]  perf_rd_o, perf_wr_o, perf_stall_o;

  cacheline_burst_adaptor dut (
    .clk(clk), .rst(rst),
    .line_addr_i(line_addr_i), .line_read_i(line_read_i), .line_write_i(line_write_i),
    .line_wdata_i(line_wdata_i), .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
    .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i),
    .perf_rd_o(perf_rd_o), .perf_wr_o(perf_wr_o), .perf_stall_o(perf_stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_wr;
    logic [255:0] line;
  } resp_t;

  resp_t       exp_resp[$];
  logic [63:0] exp_beats[$];
  logic [31:0] exp_addr;
  int          checks = 0;
  int          errors = 0;
  int          exp_rd = 0, exp_wr = 0, exp_stall = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: address and outgoing beats on every accepted beat, line on every completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_resp_i && (mem_read_o || mem_write_o)) begin
        check("mem_addr", 256'(mem_addr_o), 256'(exp_addr));
        if (mem_write_o) begin
          if (exp_beats.size() == 0) check("unexpected_wbeat", 256'(mem_wdata_o), 256'h0);
          else check("wbeat", 256'(mem_wdata_o), 256'(exp_beats.pop_front()));
        end
      end
      if (line_resp_o) begin
        if (exp_resp.size() == 0) begin
          check("unexpected_resp", 256'(line_resp_o), 256'h0);
        end else begin
          resp_t r;
          r = exp_resp.pop_front();
          if (!r.is_wr) check("rd_line", line_rdata_o, r.line);
          else check("wr_resp_no_read", 256'(mem_read_o), 256'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] aligned,
                         input logic [63:0] b[4], input logic [255:0] line, input int gaps[4]);
    bit held = 1'b1;
    exp_addr = aligned;
    exp_resp.push_back('{is_wr: 1'b0, line: line});
    line_addr_i = addr;
    line_read_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        held &= mem_read_o & ~mem_write_o;
        exp_stall++;
        tick();
      end
      held &= mem_read_o & ~mem_write_o;
      mem_rdata_i = b[i];
      mem_resp_i  = 1'b1;
      tick();
      mem_resp_i  = 1'b0;
    end
    check("rd_req_held", 256'(held), 256'h1);
    check("rd_resp_latency", {254'h0, line_resp_o, mem_read_o}, 256'h2);
    line_read_i = 1'b0;
    exp_rd++;
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] aligned,
                          input logic [255:0] line, input logic [63:0] b[4],
                          input int gaps[4], input bit also_read);
    bit held = 1'b1;
    exp_addr = aligned;
    for (int i = 0; i < 4; i++) exp_beats.push_back(b[i]);
    exp_resp.push_back('{is_wr: 1'b1, line: '0});
    line_addr_i  = addr;
    line_wdata_i = line;
    line_write_i = 1'b1;
    line_read_i  = also_read;
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        held &= mem_write_o & ~mem_read_o;
        exp_stall++;
        tick();
      end
      held &= mem_write_o & ~mem_read_o;
      mem_resp_i = 1'b1;
      tick();
      mem_resp_i = 1'b0;
    end
    check("wr_req_held", 256'(held), 256'h1);
    check("wr_resp_latency", {254'h0, line_resp_o, mem_write_o}, 256'h2);
    line_write_i = 1'b0;
    line_read_i  = 1'b0;
    exp_wr++;
    tick();
  endtask

  initial begin
    logic [63:0]  rb1[4], rb2[4], rb3[4], wb1[4], wb2[4];
    logic [255:0] rl1, rl2, rl3, wl1, wl2;
    int           g0[4], gr[4], gw1[4], gw2[4], g2[4], g1[4];

    rb1 = '{64'h0000_0000_0000_0000, 64'h1111_1111_1111_1111,
            64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333};
    rl1 = 256'h3333333333333333_2222222222222222_1111111111111111_0000000000000000;
    rb2 = '{64'hCAFE_0000_0000_0000, 64'hCAFE_0000_0000_0001,
            64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0003};
    rl2 = 256'hCAFE000000000003_CAFE000000000002_CAFE000000000001_CAFE000000000000;
    rb3 = '{64'h0123_4567_89AB_CDE0, 64'h0123_4567_89AB_CDE1,
            64'h0123_4567_89AB_CDE2, 64'h0123_4567_89AB_CDE3};
    rl3 = 256'h0123456789ABCDE3_0123456789ABCDE2_0123456789ABCDE1_0123456789ABCDE0;
    wl1 = {{15{16'hAAAA}}, 16'h0001};
    wb1 = '{64'hAAAA_AAAA_AAAA_0001, 64'hAAAA_AAAA_AAAA_AAAA,
            64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA};
    wl2 = 256'h00000000DEAD0003_00000000DEAD0002_00000000DEAD0001_00000000DEAD0000;
    wb2 = '{64'h0000_0000_DEAD_0000, 64'h0000_0000_DEAD_0001,
            64'h0000_0000_DEAD_0002, 64'h0000_0000_DEAD_0003};
    g0  = '{0, 0, 0, 0};
    g2  = '{2, 2, 2, 2};
    g1  = '{1, 1, 1, 1};
    gr  = '{2, 0, 0, 1};
    gw1 = '{0, 1, 0, 0};
    gw2 = '{0, 0, 1, 0};

    rst = 1'b1; line_addr_i = '0; line_read_i = 1'b0; line_write_i = 1'b0;
    line_wdata_i = '0; mem_rdata_i = '0; mem_resp_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_rdata", line_rdata_o, 256'h0);
    check("reset_ctl", {252'h0, line_resp_o, mem_read_o, mem_write_o, 1'b0}, 256'h0);
    check("reset_addr_wdata", {160'h0, mem_addr_o, mem_wdata_o}, 256'h0);
    check("reset_perf", {160'h0, perf_rd_o, perf_wr_o, perf_stall_o}, 256'h0);
    tick();

    do_read(32'h1234_5678, 32'h1234_5660, rb1, rl1, g0);

    // Spurious acknowledge while idle must not disturb anything.
    mem_resp_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    tick(); tick();
    mem_resp_i = 1'b0;
    check("idle_spurious_rdata", line_rdata_o, rl1);
    check("idle_spurious_ctl", {159'h0, line_resp_o, mem_read_o, mem_write_o, mem_addr_o},
          {159'h0, 3'b000, 32'h1234_5660});
    tick();

    do_write(32'h8000_003F, 32'h8000_0020, wl1, wb1, g2, 1'b0);
    do_write(32'h0000_1010, 32'h0000_1000, wl2, wb2, g1, 1'b1);
    check("rdata_kept_after_writes", line_rdata_o, rl1);

    // Reset after the second read beat abandons the burst.
    exp_addr = 32'h0000_0040;
    line_addr_i = 32'h0000_0040; line_read_i = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      mem_rdata_i = rb3[i]; mem_resp_i = 1'b1;
      tick();
    end
    mem_resp_i = 1'b0; rst = 1'b1; line_read_i = 1'b0;
    tick();
    rst = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_stall = 0;
    check("abort_ctl", {253'h0, line_resp_o, mem_read_o, mem_write_o}, 256'h0);
    check("abort_rdata_cleared", line_rdata_o, 256'h0);
    tick();
    check("abort_no_resp", 256'(line_resp_o), 256'h0);

    do_read(32'h0000_0040, 32'h0000_0040, rb2, rl2, g0);
    do_read(32'hFFFF_FFFF, 32'hFFFF_FFE0, rb3, rl3, gr);
    do_read(32'h0000_0020, 32'h0000_0020, rb1, rl1, g0);
    do_write(32'h0000_0000, 32'h0000_0000, wl1, wb1, gw1, 1'b0);
    do_write(32'h0000_0100, 32'h0000_0100, wl2, wb2, gw2, 1'b0);

    tick(); tick();
    check("pending_resps", 256'(exp_resp.size()), 256'h0);
    check("pending_wbeats", 256'(exp_beats.size()), 256'h0);
`ifdef CACHELINE_ADAPTOR_PERF_EN
    check("perf_rd", 256'(perf_rd_o), 256'd3);
    check("perf_wr", 256'(perf_wr_o), 256'd2);
    check("perf_stall", 256'(perf_stall_o), 256'd5);
    check("perf_model", 256'({exp_rd, exp_wr, exp_stall}), {160'h0, 32'd3, 32'd2, 32'd5});
`else
    check("perf_rd_off", 256'(perf_rd_o), 256'd0);
    check("perf_wr_off", 256'(perf_wr_o), 256'd0);
    check("perf_stall_off", 256'(perf_stall_o), 256'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
